// File: rtl/arch_map_retire_pkg.sv
// arch_map_retire_pkg: shared rename sizes and register-index types
package arch_map_retire_pkg;
  localparam int COMMIT_WIDTH = 4;
  localparam int SIZE_LOGICAL = 32;
  localparam int SIZE_PHYSICAL = 96;
  localparam int SIZE_LOGICAL_LOG = 5;
  localparam int SIZE_PHYSICAL_LOG = 7;
  typedef logic [SIZE_LOGICAL_LOG-1:0] log_reg_t;
  typedef logic [SIZE_PHYSICAL_LOG-1:0] phy_reg_t;
endpackage

// File: rtl/arch_map_retire_if.sv
// arch_map_retire_if: retire bundle in, released registers and architectural map out
interface arch_map_retire_if;
  import arch_map_retire_pkg::*;
  logic [COMMIT_WIDTH-1:0] commitValid;
  logic [COMMIT_WIDTH-1:0] commitHasDest;
  log_reg_t [COMMIT_WIDTH-1:0] commitLogDest;
  phy_reg_t [COMMIT_WIDTH-1:0] commitPhyDest;
  logic [COMMIT_WIDTH-1:0] freeValid;
  phy_reg_t [COMMIT_WIDTH-1:0] freeReg;
  logic [SIZE_LOGICAL*SIZE_PHYSICAL_LOG-1:0] amtMap;
  modport master (
    output commitValid, commitHasDest, commitLogDest, commitPhyDest,
    input freeValid, freeReg, amtMap
  );
  modport slave (
    input commitValid, commitHasDest, commitLogDest, commitPhyDest,
    output freeValid, freeReg, amtMap
  );
endinterface

// File: rtl/amt_bypass_4w.sv
// amt_bypass_4w: old mapping per slot, forwarding from the highest lower slot with the same destination
module amt_bypass_4w
  import arch_map_retire_pkg::*;
(
  input  logic [COMMIT_WIDTH-1:0] active_i,
  input  log_reg_t [COMMIT_WIDTH-1:0] log_dest_i,
  input  phy_reg_t [COMMIT_WIDTH-1:0] phy_dest_i,
  input  phy_reg_t [COMMIT_WIDTH-1:0] amt_rd_i,
  output phy_reg_t [COMMIT_WIDTH-1:0] old_map_o
);
  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      old_map_o[k] = amt_rd_i[k];
      for (int j = 0; j < k; j++)
        old_map_o[k] = (active_i[j] && log_dest_i[j] == log_dest_i[k]) ? phy_dest_i[j] : old_map_o[k];
    end
  end
endmodule

// File: rtl/arch_map_retire.sv
// arch_map_retire: flop-based architectural map table updated at retire, releasing superseded physical registers
module arch_map_retire
  import arch_map_retire_pkg::*;
#(
  parameter int COMMIT_WIDTH = arch_map_retire_pkg::COMMIT_WIDTH,
  parameter int SIZE_LOGICAL = arch_map_retire_pkg::SIZE_LOGICAL,
  parameter int SIZE_PHYSICAL = arch_map_retire_pkg::SIZE_PHYSICAL
) (
  input logic clk,
  input logic reset,
  arch_map_retire_if.slave bus
);
  if (COMMIT_WIDTH != arch_map_retire_pkg::COMMIT_WIDTH || SIZE_LOGICAL != arch_map_retire_pkg::SIZE_LOGICAL ||
      SIZE_PHYSICAL != arch_map_retire_pkg::SIZE_PHYSICAL) begin : g_bad_cfg
    $error("arch_map_retire: only the package sizes are supported");
  end
  logic [COMMIT_WIDTH-1:0] active;
  phy_reg_t [COMMIT_WIDTH-1:0] amt_rd, old_map;
  phy_reg_t amt_q [SIZE_LOGICAL];
  phy_reg_t amt_d [SIZE_LOGICAL];
  logic [COMMIT_WIDTH-1:0] free_valid_q, free_valid_d;
  phy_reg_t [COMMIT_WIDTH-1:0] free_reg_q, free_reg_d;
  always_comb begin
    active = bus.commitValid & bus.commitHasDest;
    for (int k = 0; k < COMMIT_WIDTH; k++) amt_rd[k] = amt_q[bus.commitLogDest[k]];
  end
  amt_bypass_4w u_bypass (
    .active_i   (active),
    .log_dest_i (bus.commitLogDest),
    .phy_dest_i (bus.commitPhyDest),
    .amt_rd_i   (amt_rd),
    .old_map_o  (old_map)
  );
  // ascending slot order lets the highest active slot own a shared destination
  always_comb begin
    amt_d = amt_q;
    for (int k = 0; k < COMMIT_WIDTH; k++)
      if (active[k]) amt_d[bus.commitLogDest[k]] = bus.commitPhyDest[k];
    free_valid_d = active;
    for (int k = 0; k < COMMIT_WIDTH; k++) free_reg_d[k] = active[k] ? old_map[k] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SIZE_LOGICAL; i++) amt_q[i] <= phy_reg_t'(i);
      free_valid_q <= '0;
      free_reg_q <= '0;
    end else begin
      amt_q <= amt_d;
      free_valid_q <= free_valid_d;
      free_reg_q <= free_reg_d;
    end
  end
  always_comb begin
    bus.freeValid = free_valid_q;
    bus.freeReg = free_reg_q;
    bus.amtMap = '0;
    for (int i = 0; i < SIZE_LOGICAL; i++) bus.amtMap[i*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG] = amt_q[i];
  end
endmodule
